// File: rtl/bus_change_recorder.sv
// Bus change recorder: samples a bus every clock and queues (value, timestamp) entries for each
// change into a FIFO drained through a valid/ready port.
module bus_change_recorder #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic [DATA_W-1:0]        bus_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [TS_W-1:0]          out_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

  state_e            state_q, state_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];
  logic [TS_W-1:0]   ts_mem_q [DEPTH];
  logic [TS_W-1:0]   ts_mem_d [DEPTH];

  logic rec, full, push, pop;

  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q;
    last_d     = last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    data_mem_d = data_mem_q;
    ts_mem_d   = ts_mem_q;
    rec        = 1'b0;

    unique case (state_q)
      StIdle: if (en) state_d = StPrime;
      StPrime: begin
        if (en) begin
          rec     = 1'b1;
          last_d  = bus_in;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (!en) begin
          state_d = StIdle;
        end else if (bus_in != last_q) begin
          rec    = 1'b1;
          last_d = bus_in;
        end
      end
      default: state_d = StIdle;
    endcase

    // Counter only advances while recording, so a PRIME entry carries the held timestamp.
    if (en && state_q != StIdle) ts_d = ts_q + TS_W'(1);

    full = (count_q == CntW'(DEPTH));
    pop  = out_valid && out_ready && !clr;
    // A same-edge pop frees the slot, so a full FIFO still accepts the push.
    push = rec && (!full || pop) && !clr;
    if (rec && full && !pop) overflow_d = 1'b1;

    if (push) begin
      data_mem_d[wr_ptr_q] = bus_in;
      ts_mem_d[wr_ptr_q]   = ts_q;
      wr_ptr_d             = wr_ptr_q + PtrW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) count_d = count_q + CntW'(1);
    if (pop && !push) count_d = count_q - CntW'(1);

    if (clr) begin
      state_d    = StIdle;
      ts_d       = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ts_q       <= '0;
      last_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      data_mem_q <= '{default: '0};
      ts_mem_q   <= '{default: '0};
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      last_q     <= last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      data_mem_q <= data_mem_d;
      ts_mem_q   <= ts_mem_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = data_mem_q[rd_ptr_q];
  assign out_ts    = ts_mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_bus_change_recorder.sv
// Directed self-checking bench for bus_change_recorder; a second instance with a 4-bit
// timestamp shares the stimulus and is used for the wrap scenario.
module tb_bus_change_recorder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] bus_in = '0;
  logic        out_ready = 1'b0;

  logic        out_valid, overflow;
  logic [31:0] out_data;
  logic [15:0] out_ts;
  logic [3:0]  count;

  logic        out_valid_s, overflow_s;
  logic [31:0] out_data_s;
  logic [3:0]  out_ts_s;
  logic [3:0]  count_s;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bus_change_recorder #(.DATA_W(32), .TS_W(16), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .bus_in(bus_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ts(out_ts),
    .count(count), .overflow(overflow)
  );

  bus_change_recorder #(.DATA_W(32), .TS_W(4), .DEPTH(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .bus_in(bus_in),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_ts(out_ts_s),
    .count(count_s), .overflow(overflow_s)
  );

  // Advance one active edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; clr = 1'b0; bus_in = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: valid=%b count=%0d ovf=%b, want 0/0/0", out_valid, count, overflow);
    end
    tests_run++;
    if (out_data !== 32'h0 || out_ts !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_head: data=%h ts=%0d, want 0/0", out_data, out_ts);
    end
  endtask

  task automatic test_prime_change();
    logic [31:0] gd [$];
    logic [15:0] gt [$];
    do_reset();
    en = 1'b1; bus_in = 32'hA5A5A5A5; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) bus_in = 32'h0000_0001;
      step();
      if (out_valid) begin gd.push_back(out_data); gt.push_back(out_ts); end
    end
    tests_run++;
    if (gd.size() !== 2) begin
      tests_failed++;
      $display("FAIL prime_count: got %0d entries, want 2", gd.size());
    end else begin
      tests_run++;
      if (gd[0] !== 32'hA5A5A5A5 || gt[0] !== 16'd0) begin
        tests_failed++;
        $display("FAIL prime_entry: got %h/%0d, want a5a5a5a5/0", gd[0], gt[0]);
      end
      tests_run++;
      if (gd[1] !== 32'h1 || gt[1] !== 16'd3) begin
        tests_failed++;
        $display("FAIL change_entry: got %h/%0d, want 00000001/3", gd[1], gt[1]);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    en = 1'b1; bus_in = 32'd100;
    step();
    for (int i = 0; i < 10; i++) begin
      bus_in = 32'd100 + 32'(i);
      step();
    end
    en = 1'b0;
    step();
    tests_run++;
    if (count !== 4'd8 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_sat: count=%0d ovf=%b, want 8/1", count, overflow);
    end
    tests_run++;
    if (out_data !== 32'd100 || out_ts !== 16'd0) begin
      tests_failed++;
      $display("FAIL ovf_head_stable: got %0d/%0d, want 100/0", out_data, out_ts);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 32'd100 + 32'(k) || out_ts !== 16'(k)) begin
        tests_failed++;
        $display("FAIL ovf_drain[%0d]: v=%b %0d/%0d, want 1 %0d/%0d",
                 k, out_valid, out_data, out_ts, 100 + k, k);
      end
      step();
    end
    tests_run++;
    if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_empty: v=%b count=%0d ovf=%b, want 0/0/1", out_valid, count, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    en = 1'b1; bus_in = 32'd200;
    step();
    for (int i = 0; i < 8; i++) begin
      bus_in = 32'd200 + 32'(i);
      step();
    end
    tests_run++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill: count=%0d ovf=%b, want 8/0", count, overflow);
    end
    bus_in = 32'd300; out_ready = 1'b1;
    step();
    en = 1'b0;
    tests_run++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_push_pop: count=%0d ovf=%b, want 8/0", count, overflow);
    end
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== ((k < 7) ? 32'd201 + 32'(k) : 32'd300) ||
          out_ts !== 16'(k + 1)) begin
        tests_failed++;
        $display("FAIL fpp_drain[%0d]: v=%b %0d/%0d, want 1 %0d/%0d",
                 k, out_valid, out_data, out_ts, (k < 7) ? 201 + k : 300, k + 1);
      end
      step();
    end
  endtask

  task automatic test_ts_wrap();
    do_reset();
    en = 1'b1; bus_in = 32'd0;
    step();
    for (int c = 0; c < 20; c++) begin
      if (c == 17) bus_in = 32'd5;
      step();
    end
    en = 1'b0;
    tests_run++;
    if (count_s !== 4'd2 || count !== 4'd2) begin
      tests_failed++;
      $display("FAIL wrap_count: small=%0d wide=%0d, want 2/2", count_s, count);
    end
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_data_s !== 32'd5 || out_ts_s !== 4'd1) begin
      tests_failed++;
      $display("FAIL wrap_ts4: got %0d/%0d, want 5/1", out_data_s, out_ts_s);
    end
    tests_run++;
    if (out_data !== 32'd5 || out_ts !== 16'd17) begin
      tests_failed++;
      $display("FAIL wrap_ts16: got %0d/%0d, want 5/17", out_data, out_ts);
    end
  endtask

  task automatic test_enable_toggle();
    do_reset();
    en = 1'b1; bus_in = 32'd7;
    repeat (4) step();
    en = 1'b0;
    repeat (5) step();
    en = 1'b1;
    repeat (2) step();
    en = 1'b0;
    tests_run++;
    if (count !== 4'd2 || out_data !== 32'd7 || out_ts !== 16'd0) begin
      tests_failed++;
      $display("FAIL en_first: count=%0d %0d/%0d, want 2 7/0", count, out_data, out_ts);
    end
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'd7 || out_ts !== 16'd3) begin
      tests_failed++;
      $display("FAIL en_reprime: v=%b %0d/%0d, want 1 7/3", out_valid, out_data, out_ts);
    end
  endtask

  task automatic test_clr();
    do_reset();
    en = 1'b1; bus_in = 32'd900;
    step();
    for (int i = 0; i < 10; i++) begin
      bus_in = 32'd900 + 32'(i);
      step();
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_flush: v=%b count=%0d ovf=%b, want 0/0/0", out_valid, count, overflow);
    end
    repeat (2) step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'd909 || out_ts !== 16'd0) begin
      tests_failed++;
      $display("FAIL clr_reprime: v=%b %0d/%0d, want 1 909/0", out_valid, out_data, out_ts);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; bus_in = 32'd50;
    step();
    for (int i = 0; i < 4; i++) begin
      bus_in = 32'd50 + 32'(i);
      step();
    end
    tests_run++;
    if (count !== 4'd4) begin
      tests_failed++;
      $display("FAIL ar_queued: count=%0d, want 4", count);
    end
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ar_immediate: v=%b count=%0d ovf=%b, want 0/0/0", out_valid, count, overflow);
    end
    #2;
    rst_n = 1'b1;
    bus_in = 32'd60;
    repeat (2) step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'd60 || out_ts !== 16'd0) begin
      tests_failed++;
      $display("FAIL ar_restart: v=%b %0d/%0d, want 1 60/0", out_valid, out_data, out_ts);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_prime_change();
    test_overflow();
    test_full_push_pop();
    test_ts_wrap();
    test_enable_toggle();
    test_clr();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
